arrow_shot_ctrl: RTL and testbench
==================================

Name: arrow_shot_ctrl

Overview:
- Shot-control stage directly upstream of the arrow mover.
- Converts the raw keyboard "shoot" level into a single-cycle launch pulse (spacePress) and produces the single-cycle terminate pulse (crash) when the arrow hits a ball or reaches the ceiling.
- Enforces one arrow in flight and a frame-counted cooldown between shots.
- Sits between the keyboard decoder/collision logic and the arrow mover, and exports shot/hit statistics to the score logic.

Parameters:
- CEIL_Y, 11'd8: arrow topLeftY at or below this value counts as a ceiling hit.
- COOLDOWN_FRAMES, 4: number of startOfFrame pulses spent in COOLDOWN after a crash (legal range 0..15).
- SETTLE_CYCLES, 2: clocks after launch during which the ceiling check is masked, while the mover loads the new Y.

Ports:
- clk  input  1  system clock
- resetN  input  1  asynchronous active-low reset
- keyShoot  input  1  raw shoot-key level from the keyboard decoder, already synchronous to clk
- startOfFrame  input  1  one-cycle pulse per frame
- arrowTopY  input  11  arrow topLeftY fed back from the arrow mover
- ballHit  input  1  arrow/ball collision level from the collision block
- spacePress  output  1  registered one-cycle launch pulse to the arrow mover
- crash  output  1  registered one-cycle terminate pulse to the arrow mover
- arrowActive  output  1  high while in FLYING
- shotCount  output  8  number of launches; saturates at 255
- hitCount  output  8  number of ball hits; saturates at 255

Behaviour:
- Clock and reset: one clock, clk. Reset resetN is asynchronous, active-low.
- Reset values:
  - State = READY.
  - spacePress = 0, crash = 0, arrowActive = 0.
  - shotCount = 0, hitCount = 0.
  - Cooldown counter = 0, settle counter = 0.
  - keyShoot history register = 1, so a key held through reset does not fire; a release is required first.
- Edge detect: rise = keyShoot & ~key_d. key_d registers keyShoot every cycle.
- READY:
  - On rise: spacePress = 1 on the next cycle (exactly one cycle), shotCount increments (saturating), state -> FLYING, settle counter loads SETTLE_CYCLES.
- FLYING:
  - arrowActive = 1.
  - The settle counter decrements each clock while nonzero.
  - Terminate condition = ballHit OR ceilHit.
    - ceilHit = startOfFrame & (settle == 0) & ((arrowTopY <= CEIL_Y) | arrowTopY[10]).
    - arrowTopY[10] set means the Y value has wrapped below zero.
  - On terminate: crash = 1 on the next cycle (one cycle only) and state -> COOLDOWN with the counter loaded to COOLDOWN_FRAMES.
  - hitCount increments (saturating) only if ballHit was the cause. If ballHit and ceilHit occur in the same cycle: one crash pulse, and hitCount increments once.
  - ballHit is ignored while the settle counter is nonzero.
- COOLDOWN:
  - The counter decrements on each startOfFrame.
  - When the counter is 0, state -> READY on the next clock. With COOLDOWN_FRAMES = 0, COOLDOWN lasts exactly one clock.
- Key rises during FLYING or COOLDOWN are discarded, not queued. After returning to READY, a new press (new rise) is required.
- spacePress and crash are never high in the same cycle. Neither is ever high for two consecutive cycles.
- Reset asserted mid-flight: all outputs return to reset values immediately (asynchronously). Counters clear.

Optional Feature:
- Macro: ARROW_AUTOFIRE_EN.
- Defined: in READY, a held key (keyShoot = 1 on entry to READY) also fires. The launch occurs on the first clock in READY with keyShoot = 1, giving continuous fire at a rate limited by flight time plus cooldown. The reset value of key_d is unchanged, so auto-fire still requires a release after reset.
- Not defined: launch only on a rising edge, as above.

Test Plan:
- Reset with keyShoot = 1, release, then press for 10 cycles -> exactly one spacePress pulse 1 cycle after the rise; shotCount = 1; arrowActive = 1.
- In FLYING, arrowTopY stepping 20 -> 8 on startOfFrame pulses -> crash one cycle after the startOfFrame with Y = 8; hitCount = 0; arrowActive drops.
- In FLYING, ballHit and ceiling condition in the same cycle -> exactly one crash pulse; hitCount = 1.
- After crash with COOLDOWN_FRAMES = 4, press the key at frames 1–3 -> no spacePress. Press after the 4th startOfFrame -> spacePress fires.
- Launch, then arrowTopY = 11'h7FF (stale) during the first 2 cycles with startOfFrame -> no crash. Later startOfFrame with arrowTopY = 11'h7FF (wrapped) -> crash.
- 256 launch/ballHit cycles -> shotCount = 255 and hitCount = 255 (saturated). Then assert resetN low mid-flight -> all outputs 0 immediately.

Source files
------------

// File: rtl/arrow_shot_ctrl_if.sv
// Signal bundle between keyboard/collision logic, arrow_shot_ctrl and the arrow mover.
// master drives the raw key/frame/feedback inputs; slave is the shot controller.
interface arrow_shot_ctrl_if;
  logic        keyShoot;
  logic        startOfFrame;
  logic [10:0] arrowTopY;
  logic        ballHit;
  logic        spacePress;
  logic        crash;
  logic        arrowActive;
  logic [7:0]  shotCount;
  logic [7:0]  hitCount;

  modport master (
    output keyShoot, startOfFrame, arrowTopY, ballHit,
    input  spacePress, crash, arrowActive, shotCount, hitCount
  );

  modport slave (
    input  keyShoot, startOfFrame, arrowTopY, ballHit,
    output spacePress, crash, arrowActive, shotCount, hitCount
  );
endinterface

// File: rtl/arrow_shot_ctrl.sv
// Shot control in front of the arrow mover: launch/terminate pulses, one arrow in flight, cooldown.
// Optional macro ARROW_AUTOFIRE_EN: a held key keeps firing whenever the controller is READY.
module arrow_shot_ctrl #(
  parameter logic [10:0] CEIL_Y          = 11'd8,
  parameter int unsigned COOLDOWN_FRAMES = 4,
  parameter int unsigned SETTLE_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              resetN,
  arrow_shot_ctrl_if.slave  bus
);

  localparam int unsigned COOL_W   = 4;
  localparam int unsigned SETTLE_W = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned Y_W      = 11;

  typedef enum logic [1:0] {
    S_READY    = 2'd0,
    S_FLYING   = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                key_q;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [COOL_W-1:0]   cool_q, cool_d;
  logic                space_q, space_d;
  logic                crash_q, crash_d;
  logic                active_q, active_d;
  logic [CNT_W-1:0]    shot_q, shot_d;
  logic [CNT_W-1:0]    hit_q, hit_d;

  logic settled;
  logic ball_hit;
  logic ceil_hit;
  logic fire;

  // Ceiling and ball checks are masked while the mover is still loading the new Y.
  assign settled  = (settle_q == '0);
  assign ball_hit = bus.ballHit & settled;
  assign ceil_hit = bus.startOfFrame & settled &
                    ((bus.arrowTopY <= CEIL_Y) | bus.arrowTopY[Y_W-1]);

`ifdef ARROW_AUTOFIRE_EN
  // armed_q remembers that the key has been seen released at least once since reset.
  logic armed_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      armed_q <= 1'b0;
    end else if (!key_q) begin
      armed_q <= 1'b1;
    end
  end

  assign fire = bus.keyShoot & (armed_q | ~key_q);
`else
  assign fire = bus.keyShoot & ~key_q;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_READY;
      key_q    <= 1'b1;
      settle_q <= '0;
      cool_q   <= '0;
      space_q  <= 1'b0;
      crash_q  <= 1'b0;
      active_q <= 1'b0;
      shot_q   <= '0;
      hit_q    <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= bus.keyShoot;
      settle_q <= settle_d;
      cool_q   <= cool_d;
      space_q  <= space_d;
      crash_q  <= crash_d;
      active_q <= active_d;
      shot_q   <= shot_d;
      hit_q    <= hit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settled ? settle_q : settle_q - SETTLE_W'(1);
    cool_d   = cool_q;
    space_d  = 1'b0;
    crash_d  = 1'b0;
    shot_d   = shot_q;
    hit_d    = hit_q;

    unique case (state_q)
      S_READY: begin
        if (fire) begin
          state_d  = S_FLYING;
          space_d  = 1'b1;
          settle_d = SETTLE_W'(SETTLE_CYCLES);
          if (shot_q != '1) shot_d = shot_q + CNT_W'(1);
        end
      end
      S_FLYING: begin
        if (ball_hit || ceil_hit) begin
          state_d = S_COOLDOWN;
          crash_d = 1'b1;
          cool_d  = COOL_W'(COOLDOWN_FRAMES);
          if (ball_hit && (hit_q != '1)) hit_d = hit_q + CNT_W'(1);
        end
      end
      S_COOLDOWN: begin
        if (cool_q == '0) begin
          state_d = S_READY;
        end else if (bus.startOfFrame) begin
          cool_d = cool_q - COOL_W'(1);
        end
      end
      default: state_d = S_READY;
    endcase

    active_d = (state_d == S_FLYING);
  end

  assign bus.spacePress  = space_q;
  assign bus.crash       = crash_q;
  assign bus.arrowActive = active_q;
  assign bus.shotCount   = shot_q;
  assign bus.hitCount    = hit_q;

endmodule

// File: tb/tb_arrow_shot_ctrl.sv
// Directed plus random bench for arrow_shot_ctrl against a per-cycle rule model.
// Honours ARROW_AUTOFIRE_EN the same way the design does.
module tb_arrow_shot_ctrl;

  localparam logic [10:0] CEIL_Y   = 11'd8;
  localparam int          COOLDOWN = 4;
  localparam int          SETTLE   = 2;

  localparam int PH_READY = 0;
  localparam int PH_FLY   = 1;
  localparam int PH_COOL  = 2;

  logic clk = 1'b0;
  logic resetN;

  arrow_shot_ctrl_if bus ();

  arrow_shot_ctrl #(
    .CEIL_Y          (CEIL_Y),
    .COOLDOWN_FRAMES (COOLDOWN),
    .SETTLE_CYCLES   (SETTLE)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: phase of the shot, what happened last clock, and the statistics.
  int m_phase, m_settle, m_frames_left, m_shot, m_hit;
  bit m_prev_key, m_released, m_space, m_crash;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_READY; m_settle = 0; m_frames_left = 0;
    m_shot = 0; m_hit = 0; m_prev_key = 1'b1; m_released = 1'b0;
    m_space = 1'b0; m_crash = 1'b0;
  endtask

  task automatic model_step(input bit k, input bit sof, input int y, input bit bh);
    bit fire, live, by_ball, by_ceil;
    m_space = 1'b0;
    m_crash = 1'b0;
    if (m_phase == PH_READY) begin
`ifdef ARROW_AUTOFIRE_EN
      fire = k && m_released;
`else
      fire = k && !m_prev_key;
`endif
      if (fire) begin
        m_space = 1'b1;
        m_shot  = (m_shot < 255) ? m_shot + 1 : 255;
        m_phase = PH_FLY;
        m_settle = SETTLE;
      end
    end else if (m_phase == PH_FLY) begin
      live    = (m_settle == 0);
      by_ball = bh && live;
      by_ceil = sof && live && ((y <= int'(CEIL_Y)) || (y >= 1024));
      if (by_ball || by_ceil) begin
        m_crash = 1'b1;
        if (by_ball) m_hit = (m_hit < 255) ? m_hit + 1 : 255;
        m_phase = PH_COOL;
        m_frames_left = COOLDOWN;
      end else if (m_settle > 0) begin
        m_settle--;
      end
    end else begin
      if (m_frames_left == 0) m_phase = PH_READY;
      else if (sof) m_frames_left--;
    end
    if (!k) m_released = 1'b1;
    m_prev_key = k;
  endtask

  // One clock: drive inputs, advance the model, check every output after the edge.
  task automatic cyc(input bit k, input bit sof, input int y, input bit bh);
    bus.keyShoot     = k;
    bus.startOfFrame = sof;
    bus.arrowTopY    = 11'(y);
    bus.ballHit      = bh;
    model_step(k, sof, y, bh);
    @(posedge clk);
    #1;
    chk("spacePress", bus.spacePress, m_space);
    chk("crash", bus.crash, m_crash);
    chk("arrowActive", bus.arrowActive, (m_phase == PH_FLY));
    chk("shotCount", bus.shotCount, m_shot);
    chk("hitCount", bus.hitCount, m_hit);
  endtask

  task automatic run(input int n, input bit k, input int y);
    repeat (n) cyc(k, 1'b0, y, 1'b0);
  endtask

  task automatic wait_cool();
    repeat (COOLDOWN) begin
      run(2, 1'b0, 100);
      cyc(1'b0, 1'b1, 100, 1'b0);
    end
    run(2, 1'b0, 100);
  endtask

  initial begin
    int cnt, idx, h0;
    bit rk;
    int ry;

    resetN = 1'b0;
    bus.keyShoot = 1'b1; bus.startOfFrame = 1'b0; bus.arrowTopY = 11'd100; bus.ballHit = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_spacePress", bus.spacePress, 0);
    chk("rst_crash", bus.crash, 0);
    chk("rst_arrowActive", bus.arrowActive, 0);
    chk("rst_shotCount", bus.shotCount, 0);
    chk("rst_hitCount", bus.hitCount, 0);
    resetN = 1'b1;

    // Key held through reset must not fire; release then a 10-cycle press fires once.
    run(5, 1'b1, 100);
    run(2, 1'b0, 100);
    cnt = 0; idx = -1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 100, 1'b0);
      if (bus.spacePress) begin cnt++; if (idx < 0) idx = i; end
    end
    chk("t1_pulses", cnt, 1);
    chk("t1_pulse_cycle", idx, 0);
    chk("t1_shot", bus.shotCount, 1);
    chk("t1_active", bus.arrowActive, 1);

    // Ceiling: Y steps 20 down to 8 on frame pulses.
    for (int y = 20; y >= 8; y -= 2) begin
      run(3, 1'b0, y);
      cyc(1'b0, 1'b1, y, 1'b0);
      if (y > 8) chk("t2_no_crash_early", bus.crash, 0);
    end
    chk("t2_crash", bus.crash, 1);
    chk("t2_hit", bus.hitCount, 0);
    chk("t2_active_drop", bus.arrowActive, 0);

    // Presses during cooldown are dropped; a press after the 4th frame fires.
    cnt = 0;
    for (int f = 0; f < COOLDOWN; f++) begin
      cyc(1'b1, 1'b0, 100, 1'b0); cnt += int'(bus.spacePress);
      cyc(1'b1, 1'b0, 100, 1'b0); cnt += int'(bus.spacePress);
      cyc(1'b0, 1'b0, 100, 1'b0); cnt += int'(bus.spacePress);
      cyc(1'b0, 1'b1, 100, 1'b0); cnt += int'(bus.spacePress);
    end
    chk("t3_no_fire_in_cooldown", cnt, 0);
    run(3, 1'b0, 100);
    cyc(1'b1, 1'b0, 100, 1'b0);
    chk("t3_fire_after_cooldown", bus.spacePress, 1);

    // Stale wrapped Y during the settle window is ignored; later it terminates.
    cyc(1'b1, 1'b1, 11'h7FF, 1'b1);
    chk("t5_settle_mask0", bus.crash, 0);
    cyc(1'b1, 1'b1, 11'h7FF, 1'b0);
    chk("t5_settle_mask1", bus.crash, 0);
    run(2, 1'b0, 11'h7FF);
    cyc(1'b0, 1'b1, 11'h7FF, 1'b0);
    chk("t5_wrap_crash", bus.crash, 1);
    chk("t5_wrap_no_hit", bus.hitCount, 0);
    wait_cool();

    // Ball hit and ceiling together: one crash, one hit.
    h0 = int'(bus.hitCount);
    cyc(1'b1, 1'b0, 100, 1'b0);
    run(3, 1'b0, 100);
    cyc(1'b0, 1'b1, 5, 1'b1);
    chk("t4_crash", bus.crash, 1);
    chk("t4_hit_once", bus.hitCount, h0 + 1);
    cyc(1'b0, 1'b1, 5, 1'b1);
    chk("t4_single_pulse", bus.crash, 0);
    wait_cool();

    // Random traffic against the model.
    rk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rk = ~rk;
      case ($urandom_range(0, 7))
        0, 1:    ry = int'($urandom_range(0, 12));
        2:       ry = int'($urandom_range(1016, 2047));
        default: ry = int'($urandom_range(9, 600));
      endcase
      cyc(rk, ($urandom_range(0, 7) == 0), ry, ($urandom_range(0, 19) == 0));
      chk("rnd_exclusive", (bus.spacePress & bus.crash), 0);
    end
    run(2, 1'b0, 100);
    repeat (6) begin
      wait_cool();
      cyc(1'b0, 1'b0, 100, 1'b1);
    end
    wait_cool();

    // Saturation of both statistics.
    for (int i = 0; i < 256; i++) begin
      cyc(1'b0, 1'b0, 100, 1'b0);
      cyc(1'b1, 1'b0, 100, 1'b0);
      run(3, 1'b1, 100);
      cyc(1'b1, 1'b0, 100, 1'b1);
      wait_cool();
    end
    chk("sat_shot", bus.shotCount, 255);
    chk("sat_hit", bus.hitCount, 255);

    // Asynchronous reset in the middle of a flight.
    cyc(1'b0, 1'b0, 100, 1'b0);
    cyc(1'b1, 1'b0, 100, 1'b0);
    cyc(1'b1, 1'b0, 100, 1'b0);
    chk("pre_rst_active", bus.arrowActive, 1);
    #2;
    resetN = 1'b0;
    #1;
    model_reset();
    chk("arst_spacePress", bus.spacePress, 0);
    chk("arst_crash", bus.crash, 0);
    chk("arst_arrowActive", bus.arrowActive, 0);
    chk("arst_shotCount", bus.shotCount, 0);
    chk("arst_hitCount", bus.hitCount, 0);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    run(4, 1'b1, 100);
    run(1, 1'b0, 100);
    cyc(1'b1, 1'b0, 100, 1'b0);
    chk("post_rst_fire", bus.spacePress, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
